// File: rtl/traffic_pkg.sv
// traffic_pkg: light-code constants, lamp bit positions, lamp-driver state
// encoding and the small combinational helpers shared by the lamp driver.
package traffic_pkg;

  // Light codes emitted by the upstream controller
  localparam logic [1:0] CODE_GREEN  = 2'd0;
  localparam logic [1:0] CODE_YELLOW = 2'd1;
  localparam logic [1:0] CODE_RED    = 2'd2;
  localparam logic [1:0] CODE_OFF    = 2'd3;

  // Bit positions inside a {red, yellow, green} lamp vector
  localparam int LAMP_G = 0;
  localparam int LAMP_Y = 1;
  localparam int LAMP_R = 2;

  // Lamp-driver state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLASH = 2'd2
  } drv_state_e;

  // Map one light code to its lamp vector; OFF gives a dark triple.
  function automatic logic [2:0] decode_code(input logic [1:0] code);
    logic [2:0] v;
    v = 3'b000;
    case (code)
      CODE_GREEN:  v[LAMP_G] = 1'b1;
      CODE_YELLOW: v[LAMP_Y] = 1'b1;
      CODE_RED:    v[LAMP_R] = 1'b1;
      default:     v = 3'b000;
    endcase
    return v;
  endfunction

  // Safe code pairs: one side red while the other is anything but off,
  // or both sides off. Everything else (two non-red lamps, or a mix of
  // off and lit) is a conflict.
  function automatic logic is_legal_pair(input logic [1:0] a, input logic [1:0] b);
    logic ok;
    ok = 1'b0;
    if ((a == CODE_OFF) && (b == CODE_OFF)) begin
      ok = 1'b1;
    end else if ((a == CODE_RED) && (b != CODE_OFF)) begin
      ok = 1'b1;
    end else if ((b == CODE_RED) && (a != CODE_OFF)) begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  // True when both directions request dark lamps.
  function automatic logic is_both_off(input logic [1:0] a, input logic [1:0] b);
    return (a == CODE_OFF) && (b == CODE_OFF);
  endfunction

endpackage

// File: rtl/traffic_blink_gen.sv
// traffic_blink_gen: free-running half-period counter producing the
// fail-safe flash phase. While clr is high the generator sits at count 0
// with phase 1, so the first cycle after clr drops starts a lit half-period.
module traffic_blink_gen
  import traffic_pkg::*;
#(
  parameter int BLINK_HALF = 25000
) (
  input  logic clk,
  input  logic RST,
  input  logic clr,
  output logic phase
);

  // One extra bit beyond clog2 keeps BLINK_HALF-1 representable for any
  // BLINK_HALF, including exact powers of two and the value 1.
  localparam int CW = $clog2(BLINK_HALF) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_count;
  logic          r_phase;

  // Half-period counter: wraps at BLINK_HALF-1 and toggles the phase there.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_count <= '0;
      r_phase <= 1'b1;
    end else if (clr) begin
      r_count <= '0;
      r_phase <= 1'b1;
    end else if (r_count == CNT_LAST) begin
      r_count <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/traffic_lamp_driver.sv
// traffic_lamp_driver: turns the controller's l1/l2 light codes into six
// lamp lines, filters unsafe code pairs and latches a flashing-yellow
// fail-safe mode until CLR_FAULT is given with a safe pair.
// Optional build macro TRAFFIC_LAMP_TEST_EN adds a LAMP_TEST input that
// lights every lamp while the driver is idle.
//
// All outputs come straight from flops (or from flops gated by the FLASH
// state flop): a code pair sampled on a clock edge is visible on the lamps
// right after that edge. o_dbg_state mirrors the FSM state register.
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int BLINK_HALF    = 25000,
  parameter int CONFLICT_FILT = 4
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [1:0] l1,
  input  logic [1:0] l2,
  input  logic       CLR_FAULT,
`ifdef TRAFFIC_LAMP_TEST_EN
  input  logic       LAMP_TEST,
`endif
  output logic [2:0] lamp1,
  output logic [2:0] lamp2,
  output logic       fault,
  output logic       conflict,
  output logic [1:0] o_dbg_state
);

  // Filter counter is wide enough to hold CONFLICT_FILT itself, so the
  // saturated value is explicit while latched in FLASH.
  localparam int FW = $clog2(CONFLICT_FILT) + 1;
  localparam logic [FW-1:0] FILT_MAX  = FW'(CONFLICT_FILT);
  localparam logic [FW-1:0] FILT_LAST = FW'(CONFLICT_FILT - 1);
  localparam logic [FW-1:0] FILT_ONE  = FW'(1);

  drv_state_e    r_state;
  drv_state_e    w_state_nxt;
  logic [FW-1:0] r_filt_cnt;
  logic [FW-1:0] w_filt_nxt;
  logic [2:0]    r_lamp1;
  logic [2:0]    r_lamp2;
  logic [2:0]    w_lamp1_nxt;
  logic [2:0]    w_lamp2_nxt;
  logic          r_conflict;

  logic          w_legal;
  logic          w_both_off;
  logic [2:0]    w_dec1;
  logic [2:0]    w_dec2;
  logic [2:0]    w_idle_lamps;
  logic          w_blink_clr;
  logic          w_phase;
  logic          w_flash_y;

  // Input classification and per-direction decode of the current pair
  assign w_legal    = is_legal_pair(l1, l2);
  assign w_both_off = is_both_off(l1, l2);
  assign w_dec1     = decode_code(l1);
  assign w_dec2     = decode_code(l2);

`ifdef TRAFFIC_LAMP_TEST_EN
  assign w_idle_lamps = LAMP_TEST ? 3'b111 : 3'b000;
`else
  assign w_idle_lamps = 3'b000;
`endif

  // Blink generator is held cleared outside FLASH, so the entry edge
  // leaves it at count 0 / phase 1 and yellows light on the first cycle.
  assign w_blink_clr = (r_state != FLASH);

  traffic_blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk   (clk),
    .RST   (RST),
    .clr   (w_blink_clr),
    .phase (w_phase)
  );

  // State, filter count, lamp and conflict registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_filt_cnt <= '0;
      r_lamp1    <= 3'b000;
      r_lamp2    <= 3'b000;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_filt_cnt <= w_filt_nxt;
      r_lamp1    <= w_lamp1_nxt;
      r_lamp2    <= w_lamp2_nxt;
      r_conflict <= ~w_legal;
    end
  end

  // Next-state, conflict filter and lamp decode. Precedence inside a state:
  // fail-safe entry first, then the exit to IDLE, then normal decode.
  always_comb begin
    w_state_nxt = r_state;
    w_filt_nxt  = r_filt_cnt;
    w_lamp1_nxt = r_lamp1;
    w_lamp2_nxt = r_lamp2;
    case (r_state)
      IDLE, RUN: begin
        if (!w_legal) begin
          if (r_filt_cnt >= FILT_LAST) begin
            // This illegal cycle completes the filter window.
            w_state_nxt = FLASH;
            w_filt_nxt  = FILT_MAX;
            w_lamp1_nxt = 3'b000;
            w_lamp2_nxt = 3'b000;
          end else begin
            // Still filtering: keep showing the last legal pair.
            w_filt_nxt = r_filt_cnt + FILT_ONE;
            if (r_state == IDLE) begin
              w_lamp1_nxt = w_idle_lamps;
              w_lamp2_nxt = w_idle_lamps;
            end
          end
        end else begin
          w_filt_nxt = '0;
          if (w_both_off) begin
            w_state_nxt = IDLE;
            if (r_state == IDLE) begin
              w_lamp1_nxt = w_idle_lamps;
              w_lamp2_nxt = w_idle_lamps;
            end else begin
              w_lamp1_nxt = 3'b000;
              w_lamp2_nxt = 3'b000;
            end
          end else begin
            w_state_nxt = RUN;
            w_lamp1_nxt = w_dec1;
            w_lamp2_nxt = w_dec2;
          end
        end
      end
      FLASH: begin
        // Latched until the operator clears it while the pair is safe.
        if (CLR_FAULT && w_legal) begin
          w_state_nxt = IDLE;
          w_filt_nxt  = '0;
          w_lamp1_nxt = 3'b000;
          w_lamp2_nxt = 3'b000;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_filt_nxt  = '0;
        w_lamp1_nxt = 3'b000;
        w_lamp2_nxt = 3'b000;
      end
    endcase
  end

  // In FLASH the lamp registers are dark and only the yellows follow the
  // blink phase; both terms come from flops.
  assign w_flash_y = (r_state == FLASH) && w_phase;

  assign lamp1       = r_lamp1 | {1'b0, w_flash_y, 1'b0};
  assign lamp2       = r_lamp2 | {1'b0, w_flash_y, 1'b0};
  assign fault       = (r_state == FLASH);
  assign conflict    = r_conflict;
  assign o_dbg_state = r_state;

endmodule
